// File: rtl/fwrisc_fetch_unit.sv
// fwrisc_fetch_unit: instruction fetch stage; splits bus words into RV32/RVC instructions.
// RVC handling (halfword buffer, straddle split) is built only when FWRISC_FETCH_COMPRESSED_EN is defined.
module fwrisc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ivalid,
    input  logic        iready,
    input  logic [31:0] idata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        fetch_valid_f,
    output logic [31:0] instr_f,
    output logic        instr_c_f,
    output logic [31:0] pc_f
);
    logic        adv;
    logic        acc;
    logic        emit;
    logic        emit_c;
    logic [31:0] emit_instr;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic        unused_ok;
    assign adv = !fetch_valid_f || !stall;
    assign acc = ivalid && iready;
    assign unused_ok = ^redirect_pc[1:0];
`ifdef FWRISC_FETCH_COMPRESSED_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
    typedef enum logic {S_FETCH, S_SPLIT} state_t;
    state_t      state;
    state_t      state_n;
    logic [15:0] hbuf;
    logic [15:0] hbuf_n;
    logic        hbuf_valid;
    logic        hbuf_valid_n;
    logic        hbuf_c;
    logic        split;
    logic        need_bus;
    assign hbuf_c = hbuf[1:0] != 2'b11;
    // A buffered non-RVC low half always needs the following word, so request it straight away.
    assign split = state == S_SPLIT || (hbuf_valid && !hbuf_c);
    assign need_bus = !(state == S_FETCH && hbuf_valid && hbuf_c);
    assign ivalid = reset && !redirect && adv && need_bus;
    assign iaddr = {pc[31:2] + (split ? 30'd1 : 30'd0), 2'b00};
    always_comb begin
        pc_n = pc;
        state_n = state;
        hbuf_n = hbuf;
        hbuf_valid_n = hbuf_valid;
        emit = 1'b0;
        emit_c = 1'b0;
        emit_instr = idata;
        if (split) begin
            state_n = acc ? S_FETCH : S_SPLIT;
            if (acc) begin
                emit = 1'b1;
                emit_instr = {idata[15:0], hbuf};
                pc_n = pc + 32'd4;
                hbuf_n = idata[31:16];
                hbuf_valid_n = 1'b1;
            end
        end else if (hbuf_valid) begin
            emit = adv;
            emit_c = 1'b1;
            emit_instr = {16'h0, hbuf};
            pc_n = adv ? pc + 32'd2 : pc;
            hbuf_valid_n = !adv;
        end else if (acc && !pc[1]) begin
            emit = 1'b1;
            emit_c = idata[1:0] != 2'b11;
            emit_instr = emit_c ? {16'h0, idata[15:0]} : idata;
            pc_n = pc + (emit_c ? 32'd2 : 32'd4);
            hbuf_n = idata[31:16];
            hbuf_valid_n = emit_c;
        end else if (acc) begin
            emit = idata[17:16] != 2'b11;
            emit_c = emit;
            emit_instr = {16'h0, idata[31:16]};
            pc_n = emit ? pc + 32'd2 : pc;
            hbuf_n = idata[31:16];
            hbuf_valid_n = !emit;
            state_n = emit ? S_FETCH : S_SPLIT;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            hbuf <= '0;
            hbuf_valid <= 1'b0;
        end else if (redirect) begin
            state <= S_FETCH;
            hbuf_valid <= 1'b0;
        end else if (adv) begin
            state <= state_n;
            hbuf <= hbuf_n;
            hbuf_valid <= hbuf_valid_n;
        end
    end
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
    assign ivalid = reset && !redirect && adv;
    assign iaddr = {pc[31:2], 2'b00};
    assign emit = acc;
    assign emit_c = 1'b0;
    assign emit_instr = idata;
    assign pc_n = acc ? pc + 32'd4 : pc;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_VECTOR & 32'hFFFF_FFFE;
            fetch_valid_f <= 1'b0;
            instr_f <= '0;
            instr_c_f <= 1'b0;
            pc_f <= '0;
        end else if (redirect) begin
            pc <= redirect_pc & PC_MASK;
            fetch_valid_f <= 1'b0;
        end else if (adv) begin
            pc <= pc_n;
            fetch_valid_f <= emit;
            if (emit) begin
                instr_f <= emit_instr;
                instr_c_f <= emit_c;
                pc_f <= pc;
            end
        end
    end
endmodule

// File: tb/tb_fwrisc_fetch_unit.sv
// tb_fwrisc_fetch_unit: directed checks of the fetch unit against a small word memory.
// Compressed scenarios run only when FWRISC_FETCH_COMPRESSED_EN is defined.
module tb_fwrisc_fetch_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        fetch_valid_f;
    logic [31:0] instr_f;
    logic        instr_c_f;
    logic [31:0] pc_f;
    int compared = 0;
    int mismatched = 0;
    int reads = 0;
    logic [31:0] ma [12];
    logic [31:0] md [12];

    fwrisc_fetch_unit dut (
        .clock(clock), .reset(reset), .iaddr(iaddr), .ivalid(ivalid), .iready(iready),
        .idata(idata), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .fetch_valid_f(fetch_valid_f), .instr_f(instr_f), .instr_c_f(instr_c_f), .pc_f(pc_f)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [31:0] d = 32'h0000_0013;
        for (int i = 0; i < 12; i++) if (ma[i] == a) d = md[i];
        return d;
    endfunction

    always @(negedge clock) idata = rd(iaddr);
    always @(posedge clock) if (reset && ivalid && iready) reads <= reads + 1;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic go_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        @(negedge clock);
        redirect = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f} !== 2'b00) begin mismatched++; $display("FAIL reset_valid_c: got %b want 00", {fetch_valid_f, instr_c_f}); end
        compared++; if (instr_f !== 32'h0) begin mismatched++; $display("FAIL reset_instr: got %h want 00000000", instr_f); end
        compared++; if (pc_f !== 32'h0) begin mismatched++; $display("FAIL reset_pc_f: got %h want 00000000", pc_f); end
        compared++; if (ivalid !== 1'b0) begin mismatched++; $display("FAIL reset_ivalid: got %b want 0", ivalid); end
    endtask

    task automatic test_first_fetch;
        reset = 1'b1;
        #1;
        compared++; if ({ivalid, iaddr} !== {1'b1, 32'h8000_0000}) begin mismatched++; $display("FAIL first_req: got %b %h want 1 80000000", ivalid, iaddr); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b10, 32'h0010_0093, 32'h8000_0000}) begin mismatched++; $display("FAIL first_instr: got %b %b %h %h want 1 0 00100093 80000000", fetch_valid_f, instr_c_f, instr_f, pc_f); end
        compared++; if (iaddr !== 32'h8000_0004) begin mismatched++; $display("FAIL first_next_addr: got %h want 80000004", iaddr); end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        #1;
        compared++; if (ivalid !== 1'b0) begin mismatched++; $display("FAIL stall_ivalid: got %b want 0", ivalid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            compared++; if ({fetch_valid_f, ivalid, instr_f, pc_f} !== {2'b10, 32'h0010_0093, 32'h8000_0000}) begin mismatched++; $display("FAIL stall_hold%0d: got %b %b %h %h want 1 0 00100093 80000000", i, fetch_valid_f, ivalid, instr_f, pc_f); end
        end
        stall = 1'b0;
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_f, pc_f} !== {1'b1, 32'h0020_0113, 32'h8000_0004}) begin mismatched++; $display("FAIL stall_release: got %b %h %h want 1 00200113 80000004", fetch_valid_f, instr_f, pc_f); end
    endtask

    task automatic test_iready_low;
        iready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            compared++; if ({ivalid, fetch_valid_f, iaddr} !== {2'b10, 32'h8000_0008}) begin mismatched++; $display("FAIL wait%0d: got %b %b %h want 1 0 80000008", i, ivalid, fetch_valid_f, iaddr); end
        end
        iready = 1'b1;
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_f, pc_f} !== {1'b1, 32'h0030_0193, 32'h8000_0008}) begin mismatched++; $display("FAIL wait_release: got %b %h %h want 1 00300193 80000008", fetch_valid_f, instr_f, pc_f); end
    endtask

    task automatic test_redirect_priority;
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0105;
        #1;
        compared++; if (ivalid !== 1'b0) begin mismatched++; $display("FAIL redir_ivalid: got %b want 0", ivalid); end
        @(negedge clock);
        redirect = 1'b0;
        stall = 1'b0;
        compared++; if ({fetch_valid_f, iaddr} !== {1'b0, 32'h0000_0104}) begin mismatched++; $display("FAIL redir_flush: got %b %h want 0 00000104", fetch_valid_f, iaddr); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b10, 32'h0050_0293, 32'h0000_0104}) begin mismatched++; $display("FAIL redir_instr: got %b %b %h %h want 1 0 00500293 00000104", fetch_valid_f, instr_c_f, instr_f, pc_f); end
    endtask

    task automatic test_wrap;
        go_redirect(32'hFFFF_FFFC);
        compared++; if (iaddr !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_addr: got %h want fffffffc", iaddr); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_f, pc_f, iaddr} !== {1'b1, 32'h0060_0313, 32'hFFFF_FFFC, 32'h0}) begin mismatched++; $display("FAIL wrap_next: got %b %h %h %h want 1 00600313 fffffffc 00000000", fetch_valid_f, instr_f, pc_f, iaddr); end
    endtask

    task automatic test_async_reset;
        #2 reset = 1'b0;
        #1;
        compared++; if ({fetch_valid_f, ivalid, instr_c_f, instr_f, pc_f, iaddr} !== {3'b000, 32'h0, 32'h0, 32'h8000_0000}) begin mismatched++; $display("FAIL async_reset: got %b %b %b %h %h %h want 0 0 0 00000000 00000000 80000000", fetch_valid_f, ivalid, instr_c_f, instr_f, pc_f, iaddr); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_f, pc_f} !== {1'b1, 32'h0010_0093, 32'h8000_0000}) begin mismatched++; $display("FAIL async_restart: got %b %h %h want 1 00100093 80000000", fetch_valid_f, instr_f, pc_f); end
    endtask

`ifdef FWRISC_FETCH_COMPRESSED_EN
    task automatic test_rvc_pair;
        int r0;
        go_redirect(32'h0000_0200);
        r0 = reads;
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f, ivalid} !== {2'b11, 32'h1, 32'h0000_0200, 1'b0}) begin mismatched++; $display("FAIL rvc_lo: got %b %b %h %h %b want 1 1 00000001 00000200 0", fetch_valid_f, instr_c_f, instr_f, pc_f, ivalid); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b11, 32'h1, 32'h0000_0202}) begin mismatched++; $display("FAIL rvc_hi: got %b %b %h %h want 1 1 00000001 00000202", fetch_valid_f, instr_c_f, instr_f, pc_f); end
        compared++; if ({reads - r0, iaddr} !== {32'd1, 32'h0000_0204}) begin mismatched++; $display("FAIL rvc_reads: got %0d %h want 1 00000204", reads - r0, iaddr); end
    endtask

    task automatic test_straddle;
        go_redirect(32'h0);
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b11, 32'h1, 32'h0}) begin mismatched++; $display("FAIL strad_lo: got %b %b %h %h want 1 1 00000001 00000000", fetch_valid_f, instr_c_f, instr_f, pc_f); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b10, 32'h0010_0093, 32'h2}) begin mismatched++; $display("FAIL strad_32: got %b %b %h %h want 1 0 00100093 00000002", fetch_valid_f, instr_c_f, instr_f, pc_f); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b11, 32'h1, 32'h6}) begin mismatched++; $display("FAIL strad_hbuf: got %b %b %h %h want 1 1 00000001 00000006", fetch_valid_f, instr_c_f, instr_f, pc_f); end
    endtask

    task automatic test_split_redirect;
        go_redirect(32'h2);
        @(negedge clock);
        iready = 1'b0;
        compared++; if ({fetch_valid_f, iaddr} !== {1'b0, 32'h4}) begin mismatched++; $display("FAIL split_enter: got %b %h want 0 00000004", fetch_valid_f, iaddr); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, ivalid, iaddr} !== {2'b01, 32'h4}) begin mismatched++; $display("FAIL split_wait: got %b %b %h want 0 1 00000004", fetch_valid_f, ivalid, iaddr); end
        go_redirect(32'h0000_0102);
        iready = 1'b1;
        compared++; if ({fetch_valid_f, iaddr} !== {1'b0, 32'h100}) begin mismatched++; $display("FAIL split_redir: got %b %h want 0 00000100", fetch_valid_f, iaddr); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b11, 32'h1, 32'h102}) begin mismatched++; $display("FAIL split_rvc: got %b %b %h %h want 1 1 00000001 00000102", fetch_valid_f, instr_c_f, instr_f, pc_f); end
    endtask
`else
    task automatic test_nocomp;
        go_redirect(32'h0000_0302);
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b10, 32'h0001_0001, 32'h300}) begin mismatched++; $display("FAIL nocomp_w0: got %b %b %h %h want 1 0 00010001 00000300", fetch_valid_f, instr_c_f, instr_f, pc_f); end
        @(negedge clock);
        compared++; if ({fetch_valid_f, instr_c_f, instr_f, pc_f} !== {2'b10, 32'h0093_0001, 32'h304}) begin mismatched++; $display("FAIL nocomp_w1: got %b %b %h %h want 1 0 00930001 00000304", fetch_valid_f, instr_c_f, instr_f, pc_f); end
    endtask
`endif

    initial begin
        ma = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h0, 32'h4,
               32'h200, 32'h100, 32'h104, 32'hFFFF_FFFC, 32'h300, 32'h304};
        md = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213, 32'h0093_0001, 32'h0001_0010,
               32'h0001_0001, 32'h0001_0000, 32'h0050_0293, 32'h0060_0313, 32'h0001_0001, 32'h0093_0001};
        reset = 1'b0;
        iready = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_iready_low();
        test_redirect_priority();
        test_wrap();
        test_async_reset();
`ifdef FWRISC_FETCH_COMPRESSED_EN
        test_rvc_pair();
        test_straddle();
        test_split_redirect();
`else
        test_nocomp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
